// File: rtl/memory_controller_if.sv
// Core memory bus: strobe/ready handshake with word-addressed loads and byte-masked stores.
interface memory_controller_if #(
    parameter int unsigned ADDRESS_SIZE = 15
) ();
    logic [ADDRESS_SIZE-1:0] address;
    logic [31:0]             dataWrite;
    logic [3:0]              writeEnable;
    logic                    strobe;
    logic [31:0]             dataRead;
    logic                    ready;

    modport master (
        output address, dataWrite, writeEnable, strobe,
        input  dataRead, ready
    );

    modport slave (
        input  address, dataWrite, writeEnable, strobe,
        output dataRead, ready
    );
endinterface

// File: rtl/memory_controller.sv
// Memory bus slave: single-port BRAM with read-modify-write for partial stores,
// plus a debug I/O window (LEDs, RGB, synchronised buttons).
module memory_controller #(
    parameter int unsigned ADDRESS_SIZE     = 15,
    parameter int unsigned RAM_ADDRESS_SIZE = 11
) (
    input  logic                        clock,
    input  logic                        reset,
    memory_controller_if.slave          bus,
    output logic [RAM_ADDRESS_SIZE-1:0] ramAddr,
    output logic [31:0]                 ramDin,
    input  logic [31:0]                 ramDout,
    output logic                        ramCe,
    output logic                        ramWre,
    input  logic                        btnA,
    input  logic                        btnB,
    output logic [7:0]                  debugBits,
    output logic [2:0]                  rgb
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        CAPTURE = 3'd2,
        MERGE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [DATA_W-1:0]           r_data;
    logic [MASK_W-1:0]           r_mask;
    logic [RAM_ADDRESS_SIZE-1:0] r_ram_addr;
    logic [DATA_W-1:0]           r_ram_din;
    logic                        r_ram_ce;
    logic                        r_ram_wre;
    logic                        r_ready;
    logic [DATA_W-1:0]           r_data_read;
    logic [7:0]                  r_debug;
    logic [2:0]                  r_rgb;
    logic [1:0]                  r_btn_meta;
    logic [1:0]                  r_btn_sync;

    logic                        w_accept;
    logic                        w_is_io;
    logic                        w_full_store;
    logic [DATA_W-1:0]           w_io_rdata;
    logic [DATA_W-1:0]           w_merged;
    logic                        w_unused;

    assign w_accept     = (r_state == IDLE) && bus.strobe;
    assign w_is_io      = bus.address[ADDRESS_SIZE-1];
    assign w_full_store = (bus.writeEnable == 4'hF);

    // Byte bits and aliasing address bits are intentionally ignored.
    assign w_unused = &{1'b0, bus.address[1:0],
                        bus.address[ADDRESS_SIZE-2:RAM_ADDRESS_SIZE+2]};

    always_comb begin
        w_io_rdata = '0;
        case (bus.address[3:2])
            2'd0:    w_io_rdata = {24'b0, r_debug};
            2'd1:    w_io_rdata = {29'b0, r_rgb};
            2'd2:    w_io_rdata = {30'b0, r_btn_sync};
            default: w_io_rdata = '0;
        endcase
    end

    // Store lanes from the latched data, remaining lanes from the captured old word.
    always_comb begin
        w_merged = ramDout;
        for (int i = 0; i < 4; i++) begin
            if (r_mask[i]) w_merged[8*i +: 8] = r_data[8*i +: 8];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.strobe) w_next = w_is_io ? DONE : ACCESS;
            ACCESS:  w_next = (r_mask == 4'hF) ? DONE : CAPTURE;
            CAPTURE: w_next = (r_mask == 4'h0) ? DONE : MERGE;
            MERGE:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; RAM strobes are derived from the next state
    // so they line up with the ACCESS and MERGE cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_mask      <= '0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_ce    <= 1'b0;
            r_ram_wre   <= 1'b0;
            r_ready     <= 1'b0;
            r_data_read <= '0;
            r_debug     <= '0;
            r_rgb       <= '0;
            r_btn_meta  <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_btn_meta <= {btnB, btnA};
            r_btn_sync <= r_btn_meta;
            r_ready    <= (w_next == DONE);
            r_ram_ce   <= (w_next == ACCESS) || (w_next == MERGE);
            r_ram_wre  <= (w_accept && !w_is_io && w_full_store) || (w_next == MERGE);

            if (w_accept) begin
                r_data <= bus.dataWrite;
                r_mask <= bus.writeEnable;
                if (w_is_io) begin
                    if (bus.writeEnable == 4'h0) begin
                        r_data_read <= w_io_rdata;
                    end else if (bus.writeEnable[0]) begin
                        case (bus.address[3:2])
                            2'd0:    r_debug <= bus.dataWrite[7:0];
                            2'd1:    r_rgb   <= bus.dataWrite[2:0];
                            default: ;
                        endcase
                    end
                end else begin
                    r_ram_addr <= bus.address[RAM_ADDRESS_SIZE+1:2];
                    r_ram_din  <= bus.dataWrite;
                end
            end

            if (r_state == CAPTURE) begin
                r_data_read <= ramDout;
                r_ram_din   <= w_merged;
            end
        end
    end

    assign bus.dataRead = r_data_read;
    assign bus.ready    = r_ready;
    assign ramAddr      = r_ram_addr;
    assign ramDin       = r_ram_din;
    assign ramCe        = r_ram_ce;
    assign ramWre       = r_ram_wre;
    assign debugBits    = r_debug;
    assign rgb          = r_rgb;
endmodule
